// File: rtl/regfile_2r1w_param.sv
// Parametrised 2-read / 1-write register file with registered reads,
// optional write-to-read bypass, optional hard-wired zero register and a
// sequential clear engine that runs after reset or on request.
module regfile_2r1w_param #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AW       = $clog2(DEPTH),
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [AW-1:0]    sel_i,
    input  logic [WIDTH-1:0] ip,
    input  logic             rd,
    input  logic [AW-1:0]    sel_o1,
    input  logic [AW-1:0]    sel_o2,
    input  logic             clr,
    output logic [WIDTH-1:0] op1,
    output logic [WIDTH-1:0] op2,
    output logic             op_valid,
    output logic             busy,
    output logic             wr_drop
);

    // Depth as an (AW+1)-bit value so range checks never overflow the select width.
    localparam logic [AW:0]   DEPTH_X  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [AW-1:0]    cidx_q;
    logic [AW-1:0]    cidx_d;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    logic [WIDTH-1:0] op1_d;
    logic [WIDTH-1:0] op2_d;
    logic             op_valid_d;
    logic             busy_d;
    logic             wr_drop_d;

    logic             wr_ok_c;
    logic [WIDTH-1:0] rdata1_c;
    logic [WIDTH-1:0] rdata2_c;

    function automatic logic in_range(input logic [AW-1:0] sel);
        return {1'b0, sel} < DEPTH_X;
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] sel);
        return ZERO_REG && (sel == '0);
    endfunction

    // An IDLE write that will actually land in the array this cycle.
    assign wr_ok_c = en && (state_q == S_IDLE) && wr && in_range(sel_i) && !is_zero_reg(sel_i);

    // Read port 1 data: forced zero, forwarded write data, or array contents.
    always_comb begin
        rdata1_c = '0;
        if (in_range(sel_o1) && !is_zero_reg(sel_o1)) begin
            if (BYPASS && wr_ok_c && (sel_o1 == sel_i)) begin
                rdata1_c = ip;
            end else begin
                rdata1_c = mem[sel_o1];
            end
        end
    end

    // Read port 2 data: same selection rules as port 1.
    always_comb begin
        rdata2_c = '0;
        if (in_range(sel_o2) && !is_zero_reg(sel_o2)) begin
            if (BYPASS && wr_ok_c && (sel_o2 == sel_i)) begin
                rdata2_c = ip;
            end else begin
                rdata2_c = mem[sel_o2];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: clear on request, return to IDLE after the last index.
    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                S_IDLE:  if (clr) state_d = S_CLEAR;
                S_CLEAR: if (cidx_q == LAST_IDX) state_d = S_IDLE;
                default: state_d = S_CLEAR;
            endcase
        end
    end

    // FSM outputs: next read data, pulses, clear index and array write port.
    always_comb begin
        op1_d      = op1;
        op2_d      = op2;
        op_valid_d = 1'b0;
        wr_drop_d  = 1'b0;
        cidx_d     = cidx_q;
        mem_we     = 1'b0;
        mem_waddr  = sel_i;
        mem_wdata  = ip;
        busy_d     = (state_d == S_CLEAR);
        if (en) begin
            case (state_q)
                S_IDLE: begin
                    mem_we    = wr_ok_c;
                    wr_drop_d = wr && !in_range(sel_i);
                    if (rd) begin
                        op1_d      = rdata1_c;
                        op2_d      = rdata2_c;
                        op_valid_d = 1'b1;
                    end
                    if (clr) begin
                        cidx_d = '0;
                    end
                end
                S_CLEAR: begin
                    mem_we    = 1'b1;
                    mem_waddr = cidx_q;
                    mem_wdata = '0;
                    cidx_d    = cidx_q + AW'(1);
                    wr_drop_d = wr;
                end
                default: ;
            endcase
        end
    end

    // Registered outputs and clear index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op1      <= '0;
            op2      <= '0;
            op_valid <= 1'b0;
            wr_drop  <= 1'b0;
            busy     <= 1'b1;
            cidx_q   <= '0;
        end else begin
            op1      <= op1_d;
            op2      <= op2_d;
            op_valid <= op_valid_d;
            wr_drop  <= wr_drop_d;
            busy     <= busy_d;
            cidx_q   <= cidx_d;
        end
    end

    // Storage array; contents are zeroed by the clear pass, not by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_regfile_2r1w_param.sv
// Bench for regfile_2r1w_param: three configurations driven in lockstep
// (16/bypass, 16/no-bypass, 12/bypass/zero-reg) against a behavioural model.
module tb_regfile_2r1w_param;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        wr;
    logic [3:0]  sel_i;
    logic [31:0] ip;
    logic        rd;
    logic [3:0]  sel_o1;
    logic [3:0]  sel_o2;
    logic        clr;

    logic [31:0] op1      [NI];
    logic [31:0] op2      [NI];
    logic        op_valid [NI];
    logic        busy     [NI];
    logic        wr_drop  [NI];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_2r1w_param #(.WIDTH(32), .DEPTH(16), .BYPASS(1'b1), .ZERO_REG(1'b0)) u0 (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .sel_i(sel_i), .ip(ip), .rd(rd),
        .sel_o1(sel_o1), .sel_o2(sel_o2), .clr(clr), .op1(op1[0]), .op2(op2[0]),
        .op_valid(op_valid[0]), .busy(busy[0]), .wr_drop(wr_drop[0]));

    regfile_2r1w_param #(.WIDTH(32), .DEPTH(16), .BYPASS(1'b0), .ZERO_REG(1'b0)) u1 (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .sel_i(sel_i), .ip(ip), .rd(rd),
        .sel_o1(sel_o1), .sel_o2(sel_o2), .clr(clr), .op1(op1[1]), .op2(op2[1]),
        .op_valid(op_valid[1]), .busy(busy[1]), .wr_drop(wr_drop[1]));

    regfile_2r1w_param #(.WIDTH(32), .DEPTH(12), .BYPASS(1'b1), .ZERO_REG(1'b1)) u2 (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .sel_i(sel_i), .ip(ip), .rd(rd),
        .sel_o1(sel_o1), .sel_o2(sel_o2), .clr(clr), .op1(op1[2]), .op2(op2[2]),
        .op_valid(op_valid[2]), .busy(busy[2]), .wr_drop(wr_drop[2]));

    // Reference model state per configuration.
    logic [31:0] m_mem   [NI][16];
    logic [31:0] m_op1   [NI];
    logic [31:0] m_op2   [NI];
    logic        m_valid [NI];
    logic        m_drop  [NI];
    int          m_left  [NI];   // clear cycles still to run; 0 = idle

    function automatic int cfg_depth(input int i);
        return (i == 2) ? 12 : 16;
    endfunction

    function automatic bit cfg_bypass(input int i);
        return i != 1;
    endfunction

    function automatic bit cfg_zero(input int i);
        return i == 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input int i, input int s, input bit wok);
        if (s >= cfg_depth(i) || (cfg_zero(i) && s == 0)) return 32'h0;
        if (cfg_bypass(i) && wok && s == int'(sel_i)) return ip;
        return m_mem[i][s];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_op1[i]   = '0;
            m_op2[i]   = '0;
            m_valid[i] = 1'b0;
            m_drop[i]  = 1'b0;
            m_left[i]  = cfg_depth(i);
        end
    endtask

    // One rising edge of the model, using the inputs held across that edge.
    task automatic model_step();
        bit wok;
        int d;
        if (!rst) return;
        for (int i = 0; i < NI; i++) begin
            d = cfg_depth(i);
            if (!en) begin
                m_valid[i] = 1'b0;
                m_drop[i]  = 1'b0;
            end else if (m_left[i] > 0) begin
                m_mem[i][d - m_left[i]] = 32'h0;
                m_left[i]--;
                m_valid[i] = 1'b0;
                m_drop[i]  = wr;
            end else begin
                wok        = wr && int'(sel_i) < d && !(cfg_zero(i) && sel_i == 4'd0);
                m_drop[i]  = wr && int'(sel_i) >= d;
                m_valid[i] = rd;
                if (rd) begin
                    m_op1[i] = model_read(i, int'(sel_o1), wok);
                    m_op2[i] = model_read(i, int'(sel_o2), wok);
                end
                if (wok) m_mem[i][sel_i] = ip;
                if (clr) m_left[i] = d;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("u%0d.op1", i), op1[i], m_op1[i]);
            check($sformatf("u%0d.op2", i), op2[i], m_op2[i]);
            check($sformatf("u%0d.op_valid", i), 32'(op_valid[i]), 32'(m_valid[i]));
            check($sformatf("u%0d.busy", i), 32'(busy[i]), 32'(m_left[i] > 0));
            check($sformatf("u%0d.wr_drop", i), 32'(wr_drop[i]), 32'(m_drop[i]));
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges, held for two edges, released.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic quiet();
        en = 1'b1; wr = 1'b0; rd = 1'b0; clr = 1'b0;
        sel_i = '0; sel_o1 = '0; sel_o2 = '0; ip = '0;
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        for (int i = 0; i < NI; i++)
            for (int r = 0; r < 16; r++) m_mem[i][r] = '0;
        @(negedge clk);

        // Reset and auto-clear with a read held pending.
        do_reset();
        rd = 1'b1; sel_o1 = 4'd3;
        repeat (17) tick();
        check("t1.op1_zero", op1[0], 32'h0);
        check("t1.valid", 32'(op_valid[0]), 32'h1);

        // Write then dual read, then hold.
        quiet();
        wr = 1'b1; sel_i = 4'd5; ip = 32'hDEADBEEF; tick();
        sel_i = 4'd9; ip = 32'h12345678; tick();
        wr = 1'b0; rd = 1'b1; sel_o1 = 4'd5; sel_o2 = 4'd9; tick();
        check("t2.op1", op1[0], 32'hDEADBEEF);
        check("t2.op2", op2[0], 32'h12345678);
        rd = 1'b0; tick();
        check("t2.hold", op1[0], 32'hDEADBEEF);
        check("t2.valid_low", 32'(op_valid[0]), 32'h0);

        // Bypass vs no-bypass on a same-cycle write and read.
        quiet();
        wr = 1'b1; sel_i = 4'd7; ip = 32'h1; tick();
        ip = 32'hAAAA5555; rd = 1'b1; sel_o1 = 4'd7; sel_o2 = 4'd7; tick();
        check("t3.byp1", op1[0], 32'hAAAA5555);
        check("t3.byp2", op2[0], 32'hAAAA5555);
        check("t3.nobyp1", op1[1], 32'h00000001);
        check("t3.nobyp2", op2[1], 32'h00000001);
        wr = 1'b0; tick();
        check("t3.nobyp_next", op1[1], 32'hAAAA5555);

        // Fill, clear request, write attempt during clear, read back.
        quiet();
        wr = 1'b1;
        for (int r = 0; r < 16; r++) begin
            sel_i = 4'(r); ip = 32'h01010101 * 32'(r + 1); tick();
        end
        wr = 1'b0; clr = 1'b1; tick();
        clr = 1'b0; wr = 1'b1; sel_i = 4'd2; ip = 32'hCAFE0002; tick();
        check("t4.wr_drop", 32'(wr_drop[0]), 32'h1);
        check("t4.busy", 32'(busy[0]), 32'h1);
        wr = 1'b0;
        repeat (16) tick();
        rd = 1'b1;
        for (int r = 0; r < 16; r++) begin
            sel_o1 = 4'(r); sel_o2 = 4'(15 - r); tick();
            check("t4.cleared", op1[0], 32'h0);
        end

        // Out-of-range and zero-register behaviour on the 12-deep instance.
        quiet();
        wr = 1'b1; sel_i = 4'd13; ip = 32'hFF; tick();
        check("t5.oor_drop", 32'(wr_drop[2]), 32'h1);
        wr = 1'b0; rd = 1'b1; sel_o1 = 4'd13; tick();
        check("t5.oor_read", op1[2], 32'h0);
        check("t5.oor_valid", 32'(op_valid[2]), 32'h1);
        rd = 1'b0; wr = 1'b1; sel_i = 4'd0; tick();
        check("t5.zero_nodrop", 32'(wr_drop[2]), 32'h0);
        wr = 1'b0; rd = 1'b1; sel_o1 = 4'd0; tick();
        check("t5.zero_read", op1[2], 32'h0);
        check("t5.reg0_normal", op1[0], 32'hFF);

        // Enable gating mid-clear, then reset mid-clear.
        quiet();
        clr = 1'b1; tick();
        clr = 1'b0; repeat (4) tick();
        en = 1'b0; repeat (5) tick();
        check("t6.busy_frozen", 32'(busy[0]), 32'h1);
        en = 1'b1; repeat (13) tick();
        clr = 1'b1; tick();
        clr = 1'b0; repeat (8) tick();
        do_reset();
        rd = 1'b1; sel_o1 = 4'd4;
        repeat (15) tick();
        check("t6.busy_after_rst", 32'(busy[0]), 32'h1);
        repeat (3) tick();

        // Randomised traffic, including rare clears and resets.
        for (int c = 0; c < 3000; c++) begin
            en     = ($urandom_range(0, 9) != 0);
            wr     = $urandom_range(0, 1) == 1;
            rd     = $urandom_range(0, 1) == 1;
            clr    = ($urandom_range(0, 59) == 0);
            sel_i  = 4'($urandom_range(0, 15));
            sel_o1 = 4'($urandom_range(0, 15));
            sel_o2 = ($urandom_range(0, 3) == 0) ? sel_o1 : 4'($urandom_range(0, 15));
            ip     = $urandom;
            if ($urandom_range(0, 999) == 0) do_reset();
            else tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w_param.md
# regfile_2r1w_param

Parametrised two-read, one-write register file for the datapath. It is the successor to the fixed 16×32 register file and adds:
- configurable width and depth
- registered reads with a valid flag
- optional write-to-read bypass and an optional hard-wired zero register
- a sequential clear engine that runs after reset or on request

It sits between instruction decode (`sel_*`, `rd`, `wr`) and the ALU operand inputs (`op1`, `op2`).

## Interface
- `WIDTH`, 32, data width in bits.
- `DEPTH`, 16, number of registers (≥2; need not be a power of two).
- `AW`, `$clog2(DEPTH)`, select width (derived; do not override).
- `BYPASS`, 1, 1 = a same-cycle write is forwarded to a matching read; 0 = the read returns the old contents.
- `ZERO_REG`, 0, 1 = register 0 reads as 0 and ignores writes.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `en` input 1: global enable; when 0 the block is frozen (no read, write or clear progress).
- `wr` input 1: write request.
- `sel_i` input AW: write select.
- `ip` input WIDTH: write data.
- `rd` input 1: read request.
- `sel_o1` input AW: read select, port 1.
- `sel_o2` input AW: read select, port 2.
- `clr` input 1: clear request (single-cycle pulse or level).
- `op1` output WIDTH: read data, port 1 (registered).
- `op2` output WIDTH: read data, port 2 (registered).
- `op_valid` output 1: one-cycle pulse, `op1`/`op2` updated this cycle.
- `busy` output 1: clear engine active.
- `wr_drop` output 1: one-cycle pulse, a write request was discarded.

## Operation
**FSM states:** IDLE and CLEAR. The clear index `cidx` is AW bits wide.

**Reset** (`rst`=0, asynchronous):
- `op1`=0, `op2`=0, `op_valid`=0, `wr_drop`=0.
- State = CLEAR, `cidx`=0, `busy`=1.
- Array contents are not reset directly; the CLEAR pass zeroes them.

**CLEAR** (`en`=1):
- Each cycle write 0 to `regFile[cidx]` and increment `cidx`.
- After writing `DEPTH-1`, go to IDLE.
- `en`=0 holds `cidx`.
- Reads are ignored in CLEAR: `op_valid` stays 0 and outputs hold.
- Writes are ignored in CLEAR and pulse `wr_drop`.
- `clr` is ignored in CLEAR (no restart).

**IDLE** (`en`=1):
- `clr`=1 → CLEAR with `cidx`=0. Any `rd`/`wr` in that same cycle is still serviced normally.
- `wr`=1 writes `ip` to `regFile[sel_i]` at the edge.
- `rd`=1 loads `op1`←`regFile[sel_o1]` and `op2`←`regFile[sel_o2]`, and pulses `op_valid`.
- `rd`=0: `op1`/`op2` hold their last value.

**Boundary rules:**
- **Bypass:** with `rd`&`wr` in the same cycle and `sel_oN`==`sel_i`:
  - `BYPASS`=1: `opN` gets `ip`.
  - `BYPASS`=0: `opN` gets the pre-write contents.
- **Both read ports** may select the same register; both return identical data.
- **Out-of-range select** (≥`DEPTH`): a write is discarded and pulses `wr_drop`; a read returns 0 on that port and still pulses `op_valid`.
- **`ZERO_REG`=1:**
  - Writes to register 0 are discarded silently (no `wr_drop`).
  - Reads of register 0 return 0, including under bypass.
- **`en`=0:** no state changes; `op_valid` and `wr_drop` are 0.
- **Width:** data is passed unchanged, with no extension or truncation.

## Timing
- **Read latency:** 1 cycle. `rd` sampled at edge N → `op1`/`op2`/`op_valid` valid after edge N.
- **Write:** visible to a read sampled at the next edge (or the same edge when `BYPASS`=1).
- **CLEAR duration:** exactly `DEPTH` enabled cycles. `busy` falls after the edge that writes `DEPTH-1`; a read sampled at that same edge is ignored.
- **After reset release:** `busy`=1 for `DEPTH` enabled cycles before the first read or write is accepted.
- **Reset mid-operation:** asynchronous return to CLEAR with `cidx`=0. A pending read result is lost (`op_valid`=0), and a partial CLEAR restarts from 0.
- **Pulse outputs:** `wr_drop` is registered and asserts the cycle after the dropped request.

## Test plan
1. **Reset and auto-clear.**
   - Stimulus: release `rst` with `en`=1 and defaults; hold `rd`=1, `sel_o1`=3.
   - Response: `busy`=1 for 16 cycles, `op_valid`=0 throughout. First read after `busy` falls gives `op1`=0x00000000 with `op_valid`=1.
2. **Write, then dual read.**
   - Stimulus: write 0xDEADBEEF to reg 5 and 0x12345678 to reg 9; next cycle `rd` with `sel_o1`=5, `sel_o2`=9.
   - Response: one cycle later `op1`=0xDEADBEEF, `op2`=0x12345678, `op_valid` pulses once. With `rd`=0 the outputs hold.
3. **Bypass.**
   - Stimulus: reg 7=0x1; same cycle `wr` 0xAAAA5555→reg 7 and `rd` `sel_o1`=7, `sel_o2`=7.
   - Response: `BYPASS`=1 gives both outputs 0xAAAA5555. `BYPASS`=0 gives both 0x00000001; a read the following cycle gives 0xAAAA5555.
4. **Clear request.**
   - Stimulus: fill regs 0–15 with nonzero values; pulse `clr`; during CLEAR attempt a write to reg 2.
   - Response: `busy`=1 for 16 cycles, `wr_drop` pulses, and all regs read 0 afterwards.
5. **`DEPTH`=12, `ZERO_REG`=1.**
   - Write 0xFF to reg 13 → `wr_drop`=1.
   - Read `sel_o1`=13 → `op1`=0.
   - Write 0xFF to reg 0 → no `wr_drop`; a subsequent read returns 0.
6. **Enable gating and reset mid-CLEAR.**
   - `en`=0 for 5 cycles mid-CLEAR → `busy` stays 1 and CLEAR still totals 16 enabled cycles.
   - Assert `rst` at `cidx`=8 → after release, `busy`=1 for a full 16 cycles.
